cw_sequencer: RTL

//   Control-word sequencer for datapath_memory bring-up on the DE0/GPIO board. Replaces the static DIP_SW/SW control word.
//   The host preloads a FIFO of control words; the sequencer issues them one per clock (RUN) or one per step press (IDLE).
//   It drives an all-zero NOP word between issues. It latches status after each issued word.
//   It can halt on the datapath's unregistered zero flag.

---
 rtl/cw_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cw_sequencer.sv
// cw_sequencer
//   Control-word sequencer for datapath_memory bring-up. The host preloads
//   a circular FIFO of control words. The sequencer then issues them one per
//   clock while running, or one per step press while idle. Between issues it
//   drives the all-zero NOP word. While a word is on the bus, the sequencer
//   records the datapath status. It can optionally stop on the unregistered
//   zero flag.
//
//   Ports
//     clock, reset   single clock, synchronous active-high reset
//     cw_in          control word to enqueue
//     cw_in_valid    enqueue request
//     cw_in_ready    FIFO not full (combinational)
//     run            level: free-run issue when high
//     step           single-step request; its rising edge issues while idle
//     halt_on_z      enter HALT when status[0] is set during an issued word
//     flush          empty the FIFO and return to IDLE
//     status         {V,C,N,Z,Znot_registered} from the datapath
//     ControlWord    registered word to the datapath, 0 = NOP
//     cw_active      high while ControlWord holds an issued word
//     state          IDLE=0, RUN=1, HALT=2
//     fifo_level     entries held, 0..DEPTH
//     issue_count    words issued since reset/flush (wraps)
//     last_status    status seen in the last cycle with cw_active=1
module cw_sequencer #(
  parameter int CW_WIDTH = 37,
  parameter int DEPTH    = 8,
  parameter int LVL_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CW_WIDTH-1:0] cw_in,
  input  logic                cw_in_valid,
  output logic                cw_in_ready,
  input  logic                run,
  input  logic                step,
  input  logic                halt_on_z,
  input  logic                flush,
  input  logic [4:0]          status,
  output logic [CW_WIDTH-1:0] ControlWord,
  output logic                cw_active,
  output logic [1:0]          state,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [15:0]         issue_count,
  output logic [4:0]          last_status
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW_WIDTH-1:0] cw_q, cw_d;
  logic                cw_active_q, cw_active_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [15:0]         issue_count_q, issue_count_d;
  logic [4:0]          last_status_q, last_status_d;
  logic                step_q, step_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;

  // The head entry must be available in the same cycle as the pop decision.
  // For that reason the storage is read asynchronously. It is small enough
  // to sit in distributed RAM.
  logic [CW_WIDTH-1:0] mem_q [DEPTH];
  logic [CW_WIDTH-1:0] head;

  logic full, empty, step_pulse, halt_hit, issue_ok, push, pop;

  assign head       = mem_q[rd_ptr_q];
  assign full       = (level_q == LVL_W'(DEPTH));
  assign empty      = (level_q == '0);
  assign step_pulse = step & ~step_q;
  // Uses the live zero flag of the word currently driven, so the next word
  // is held back at this edge.
  assign halt_hit   = halt_on_z & cw_active_q & status[0];
  assign issue_ok   = ~empty & ~halt_hit &
                      (((state_q == S_RUN) & run) |
                       ((state_q == S_IDLE) & ~run & step_pulse));
  // Flush drops both an enqueue and an issue in its cycle.
  // A push into a full FIFO is refused even if a pop frees a slot at the same edge.
  assign push       = cw_in_valid & ~full & ~flush;
  assign pop        = issue_ok & ~flush;

  always_comb begin
    state_d       = state_q;
    cw_d          = '0;
    cw_active_d   = 1'b0;
    level_d       = level_q;
    issue_count_d = issue_count_q;
    last_status_d = last_status_q;
    step_d        = step;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    case (state_q)
      S_IDLE:  if (run) state_d = S_RUN;
      S_RUN: begin
        if (halt_hit)  state_d = S_HALT;
        else if (!run) state_d = S_IDLE;
      end
      S_HALT:  if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cw_active_q) last_status_d = status;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      cw_d          = head;
      cw_active_d   = 1'b1;
      issue_count_d = issue_count_q + 16'd1;
    end
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    if (flush) begin
      state_d       = S_IDLE;
      level_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      issue_count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cw_q          <= '0;
      cw_active_q   <= 1'b0;
      level_q       <= '0;
      issue_count_q <= '0;
      last_status_q <= '0;
      step_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      cw_q          <= cw_d;
      cw_active_q   <= cw_active_d;
      level_q       <= level_d;
      issue_count_q <= issue_count_d;
      last_status_q <= last_status_d;
      step_q        <= step_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= cw_in;
  end

  assign cw_in_ready = ~full;
  assign ControlWord = cw_q;
  assign cw_active   = cw_active_q;
  assign state       = state_q;
  assign fifo_level  = level_q;
  assign issue_count = issue_count_q;
  assign last_status = last_status_q;

endmodule
